// File: rtl/clk_pkg_57.sv
// Shared definitions for the clock time-setting logic: state encoding,
// seconds scaling and the default key timing values.
package clk_pkg_57;

  localparam logic [2:0] ST_RUN  = 3'd0;
  localparam logic [2:0] ST_HOUR = 3'd1;
  localparam logic [2:0] ST_MIN  = 3'd2;
  localparam logic [2:0] ST_SEC  = 3'd3;
  localparam logic [2:0] ST_WEEK = 3'd4;

  localparam int MS_PER_S           = 1000;
  localparam int TIMEOUT_S_DFLT     = 10;
  localparam int REPEAT_DLY_MS_DFLT = 600;
  localparam int REPEAT_PER_MS_DFLT = 150;
  localparam int BLINK_HALF_MS_DFLT = 250;

  typedef enum logic [2:0] {
    S_RUN  = ST_RUN,
    S_HOUR = ST_HOUR,
    S_MIN  = ST_MIN,
    S_SEC  = ST_SEC,
    S_WEEK = ST_WEEK
  } state_e;

  // Order in which the mode key walks through the editable fields.
  function automatic state_e next_field(input state_e s);
    case (s)
      S_RUN:   return S_HOUR;
      S_HOUR:  return S_MIN;
      S_MIN:   return S_SEC;
      S_SEC:   return S_WEEK;
      default: return S_RUN;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat_57.sv
// Rising-edge detector plus hold-to-repeat timer for one adjust key.
// req_o asks for a pulse on a fresh press and on every repeat interval.
module key_repeat_57 #(
  parameter int REPEAT_DLY_MS = clk_pkg_57::REPEAT_DLY_MS_DFLT,
  parameter int REPEAT_PER_MS = clk_pkg_57::REPEAT_PER_MS_DFLT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic key_i,
  input  logic inh_i,
  output logic rise_o,
  output logic req_o
);

  localparam int MAXV = (REPEAT_DLY_MS > REPEAT_PER_MS) ? REPEAT_DLY_MS : REPEAT_PER_MS;
  localparam int CW   = $clog2(MAXV + 1);

  logic          prev_q, arm_q;
  logic          act_q, act_d;
  logic          first_q, first_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep;

  // arm_q masks the first cycle after reset so a key held through release is not an edge.
  assign rise_o = key_i & ~prev_q & arm_q;

  always_comb begin
    act_d   = act_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    rep     = 1'b0;
    if (inh_i || !key_i) begin
      act_d   = 1'b0;
      first_d = 1'b0;
      cnt_d   = '0;
    end else if (rise_o) begin
      act_d   = 1'b1;
      first_d = 1'b1;
      cnt_d   = '0;
    end else if (act_q && tick_i) begin
      if (cnt_q == CW'(first_q ? REPEAT_DLY_MS - 1 : REPEAT_PER_MS - 1)) begin
        rep     = 1'b1;
        first_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign req_o = (rise_o | rep) & ~inh_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      arm_q   <= 1'b0;
      act_q   <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= key_i;
      arm_q   <= 1'b1;
      act_q   <= act_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/set_mode_ctrl_57.sv
// Time-setting sequencer: mode key selects the field, add/sub keys make
// single or auto-repeating adjust pulses, with blink and idle timeout.
module set_mode_ctrl_57 #(
  parameter int TIMEOUT_S     = clk_pkg_57::TIMEOUT_S_DFLT,
  parameter int REPEAT_DLY_MS = clk_pkg_57::REPEAT_DLY_MS_DFLT,
  parameter int REPEAT_PER_MS = clk_pkg_57::REPEAT_PER_MS_DFLT,
  parameter int BLINK_HALF_MS = clk_pkg_57::BLINK_HALF_MS_DFLT,
  parameter int MS_PER_S      = clk_pkg_57::MS_PER_S
) (
  input  logic clk_50m_57,
  input  logic rst_57,
  input  logic tick_ms_57,
  input  logic key_mode_57,
  input  logic key_add_57,
  input  logic key_sub_57,
  output logic hour_e_57,
  output logic min_e_57,
  output logic sec_e_57,
  output logic week_e_57,
  output logic add_p_57,
  output logic sub_p_57,
  output logic blink_on_57,
  output logic time_run_57
);

  import clk_pkg_57::*;

  localparam int MSW = $clog2(MS_PER_S + 1);
  localparam int SW  = $clog2(TIMEOUT_S + 1);
  localparam int BW  = $clog2(BLINK_HALF_MS + 1);

  state_e         state_q, state_d;
  logic           mode_prev_q, arm_q;
  logic [MSW-1:0] ms_q, ms_d;
  logic [SW-1:0]  idle_q, idle_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           blink_q, blink_d;
  logic           add_p_q, add_p_d, sub_p_q, sub_p_d;
  logic           hour_e_q, min_e_q, sec_e_q, week_e_q, run_q;

  logic mode_rise, in_set, timeout;
  logic add_rise, add_req, sub_rise, sub_req;
  logic add_inh, sub_inh, activity;

  assign mode_rise = key_mode_57 & ~mode_prev_q & arm_q;
  assign in_set    = (state_q != S_RUN);

  // Opposite key held or a mode edge blocks a key and drops its repeat.
  assign add_inh = ~in_set | mode_rise | key_sub_57;
  assign sub_inh = ~in_set | mode_rise | key_add_57;

  key_repeat_57 #(
    .REPEAT_DLY_MS (REPEAT_DLY_MS),
    .REPEAT_PER_MS (REPEAT_PER_MS)
  ) u_add (
    .clk_i  (clk_50m_57),
    .rst_i  (rst_57),
    .tick_i (tick_ms_57),
    .key_i  (key_add_57),
    .inh_i  (add_inh),
    .rise_o (add_rise),
    .req_o  (add_req)
  );

  key_repeat_57 #(
    .REPEAT_DLY_MS (REPEAT_DLY_MS),
    .REPEAT_PER_MS (REPEAT_PER_MS)
  ) u_sub (
    .clk_i  (clk_50m_57),
    .rst_i  (rst_57),
    .tick_i (tick_ms_57),
    .key_i  (key_sub_57),
    .inh_i  (sub_inh),
    .rise_o (sub_rise),
    .req_o  (sub_req)
  );

  assign add_p_d  = add_req & ~add_p_q;
  assign sub_p_d  = sub_req & ~sub_p_q;
  assign activity = mode_rise | add_rise | sub_rise | add_req | sub_req;

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    idle_d  = idle_q;
    timeout = 1'b0;
    if (!in_set || activity) begin
      ms_d   = '0;
      idle_d = '0;
    end else if (tick_ms_57) begin
      if (ms_q == MSW'(MS_PER_S - 1)) begin
        ms_d = '0;
        if (idle_q == SW'(TIMEOUT_S - 1)) begin
          timeout = 1'b1;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + SW'(1);
        end
      end else begin
        ms_d = ms_q + MSW'(1);
      end
    end
    if (mode_rise) begin
      state_d = next_field(state_q);
    end else if (timeout) begin
      state_d = S_RUN;
    end
  end

  // Blink restarts visible on any field change or adjust pulse.
  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (!in_set || (state_d != state_q) || add_p_d || sub_p_d) begin
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else if (tick_ms_57) begin
      if (bcnt_q == BW'(BLINK_HALF_MS - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_50m_57 or posedge rst_57) begin
    if (rst_57) begin
      state_q     <= S_RUN;
      mode_prev_q <= 1'b0;
      arm_q       <= 1'b0;
      ms_q        <= '0;
      idle_q      <= '0;
      bcnt_q      <= '0;
      blink_q     <= 1'b1;
      add_p_q     <= 1'b0;
      sub_p_q     <= 1'b0;
      hour_e_q    <= 1'b0;
      min_e_q     <= 1'b0;
      sec_e_q     <= 1'b0;
      week_e_q    <= 1'b0;
      run_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= key_mode_57;
      arm_q       <= 1'b1;
      ms_q        <= ms_d;
      idle_q      <= idle_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      add_p_q     <= add_p_d;
      sub_p_q     <= sub_p_d;
      hour_e_q    <= (state_q == S_HOUR);
      min_e_q     <= (state_q == S_MIN);
      sec_e_q     <= (state_q == S_SEC);
      week_e_q    <= (state_q == S_WEEK);
      run_q       <= (state_q != S_SEC);
    end
  end

  assign hour_e_57   = hour_e_q;
  assign min_e_57    = min_e_q;
  assign sec_e_57    = sec_e_q;
  assign week_e_57   = week_e_q;
  assign add_p_57    = add_p_q;
  assign sub_p_57    = sub_p_q;
  assign blink_on_57 = blink_q;
  assign time_run_57 = run_q;

endmodule

// File: tb/tb_set_mode_ctrl_57.sv
// Directed bench for set_mode_ctrl_57 with a ms tick on every other clock.
module tb_set_mode_ctrl_57;

  logic clk_50m_57 = 1'b0;
  logic rst_57, tick_ms_57, key_mode_57, key_add_57, key_sub_57;
  logic hour_e_57, min_e_57, sec_e_57, week_e_57;
  logic add_p_57, sub_p_57, blink_on_57, time_run_57;

  int   checks = 0;
  int   errors = 0;
  int   tk = 0;
  int   na = 0;
  int   ns = 0;
  int   wk = 6;
  int   padd [8];
  logic tick_ph = 1'b0;
  logic prev_add = 1'b0;
  logic prev_sub = 1'b0;

  always #10 clk_50m_57 = ~clk_50m_57;

  set_mode_ctrl_57 dut (
    .clk_50m_57  (clk_50m_57),
    .rst_57      (rst_57),
    .tick_ms_57  (tick_ms_57),
    .key_mode_57 (key_mode_57),
    .key_add_57  (key_add_57),
    .key_sub_57  (key_sub_57),
    .hour_e_57   (hour_e_57),
    .min_e_57    (min_e_57),
    .sec_e_57    (sec_e_57),
    .week_e_57   (week_e_57),
    .add_p_57    (add_p_57),
    .sub_p_57    (sub_p_57),
    .blink_on_57 (blink_on_57),
    .time_run_57 (time_run_57)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int fld();
    return int'({hour_e_57, min_e_57, sec_e_57, week_e_57});
  endfunction

  function automatic int misc();
    return int'({add_p_57, sub_p_57, blink_on_57, time_run_57});
  endfunction

  // One clock: observe outputs on the falling edge, count consumed ticks and pulses.
  task automatic step();
    @(negedge clk_50m_57);
    if (tick_ms_57) tk++;
    if (add_p_57) begin
      chk("add_gap", int'(prev_add), 0);
      if (na < 8) padd[na] = tk;
      na++;
      wk = (wk == 7) ? 1 : wk + 1;
    end
    if (sub_p_57) begin
      chk("sub_gap", int'(prev_sub), 0);
      ns++;
    end
    prev_add   = add_p_57;
    prev_sub   = sub_p_57;
    tick_ms_57 = tick_ph;
    tick_ph    = ~tick_ph;
  endtask

  task automatic ticks(input int n);
    int t0 = tk;
    int g  = 0;
    while ((tk - t0 < n) && (g < 4 * n + 10)) begin
      step();
      g++;
    end
  endtask

  task automatic press_mode();
    key_mode_57 = 1'b1;
    repeat (3) step();
    key_mode_57 = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    int exp_f [5] = '{8, 4, 2, 1, 0};
    int exp_r [5] = '{1, 1, 0, 1, 1};
    int ts, te, tp, g;

    for (int i = 0; i < 8; i++) padd[i] = 0;
    rst_57 = 1'b1; tick_ms_57 = 1'b0;
    key_mode_57 = 1'b0; key_add_57 = 1'b0; key_sub_57 = 1'b0;
    repeat (3) step();
    chk("rst_fld", fld(), 0);
    chk("rst_misc", misc(), 3);
    rst_57 = 1'b0;
    repeat (3) step();
    chk("idle_fld", fld(), 0);

    for (int i = 0; i < 5; i++) begin
      press_mode();
      chk("mode_fld", fld(), exp_f[i]);
      chk("mode_run", int'(time_run_57), exp_r[i]);
    end

    na = 0;
    key_add_57 = 1'b1;
    repeat (6) step();
    key_add_57 = 1'b0;
    repeat (3) step();
    chk("run_add", na, 0);
    chk("run_blink", int'(blink_on_57), 1);

    repeat (4) press_mode();
    chk("week_fld", fld(), 1);
    na = 0; wk = 6;
    key_add_57 = 1'b1;
    ticks(1000);
    key_add_57 = 1'b0;
    repeat (4) step();
    chk("rep_cnt", na, 4);
    chk("rep_dly", padd[1] - padd[0], 600);
    chk("rep_per1", padd[2] - padd[1], 150);
    chk("rep_per2", padd[3] - padd[2], 150);
    chk("week_wrap", wk, 3);

    key_add_57 = 1'b1;
    repeat (4) step();
    na = 0; ns = 0;
    key_sub_57 = 1'b1;
    ticks(700);
    key_sub_57 = 1'b0;
    ticks(700);
    chk("both_none", na + ns, 0);
    key_add_57 = 1'b0;
    repeat (3) step();
    key_sub_57 = 1'b1;
    repeat (3) step();
    key_sub_57 = 1'b0;
    repeat (3) step();
    chk("sub_one", ns, 1);
    chk("sub_noadd", na, 0);

    press_mode();
    chk("back_run", fld(), 0);
    press_mode();
    chk("hour_fld", fld(), 8);
    na = 0;
    key_mode_57 = 1'b1;
    key_add_57  = 1'b1;
    step();
    ts = tk;
    g  = 0;
    while (blink_on_57 && g < 2000) begin step(); g++; end
    chk("blink_lo", tk - ts, 250);
    chk("prio_fld", fld(), 4);
    g = 0;
    while (!blink_on_57 && g < 2000) begin step(); g++; end
    chk("blink_hi", tk - ts, 500);
    ticks(700 - (tk - ts));
    chk("prio_add", na, 0);
    key_mode_57 = 1'b0;
    key_add_57  = 1'b0;
    repeat (3) step();

    repeat (3) press_mode();
    chk("pre_tmo", fld(), 0);
    key_mode_57 = 1'b1;
    step();
    te = tk;
    key_mode_57 = 1'b0;
    g = 0;
    while ((tk - te < 9900) && g < 30000) begin step(); g++; end
    key_add_57 = 1'b1;
    step();
    tp = tk;
    key_add_57 = 1'b0;
    g = 0;
    while (hour_e_57 && g < 25000) begin step(); g++; end
    chk("tmo_press", tk - tp, 10000);
    chk("tmo_entry", tk - te, 19900);
    chk("tmo_fld", fld(), 0);
    chk("tmo_run", int'(time_run_57), 1);

    press_mode();
    press_mode();
    chk("min_fld", fld(), 4);
    key_add_57 = 1'b1;
    repeat (4) step();
    rst_57 = 1'b1;
    #1;
    chk("arst_fld", fld(), 0);
    chk("arst_misc", misc(), 3);
    step();
    rst_57 = 1'b0;
    na = 0;
    ticks(700);
    chk("rel_add", na, 0);
    chk("rel_fld", fld(), 0);
    key_add_57 = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_mode_ctrl_57.md
Name: set_mode_ctrl_57

Overview:
Time-setting sequencer for the digital clock. Turns the three debounced front-panel keys into per-field adjust enables (hour/minute/second/week) plus single-cycle add/sub pulses with hold-to-repeat. Also drives a blink flag for the display and a run-enable that freezes seconds while they are being set. Sits between the key debouncers and the hour/min/sec counters and week_ctrl_57.

Parameters:
TIMEOUT_S, 10, whole seconds of key inactivity in any SET state before auto-return to RUN
REPEAT_DLY_MS, 600, add/sub hold time before the first auto-repeat pulse
REPEAT_PER_MS, 150, auto-repeat pulse period after the first repeat
BLINK_HALF_MS, 250, half-period of blink_on_57
MS_PER_S, 1000, tick_ms_57 pulses per second

Ports:
clk_50m_57  in  1  50 MHz system clock
rst_57      in  1  asynchronous, active-high reset
tick_ms_57  in  1  1-cycle pulse every 1 ms
key_mode_57 in  1  debounced, synchronised mode key level, 1 = pressed
key_add_57  in  1  debounced add key level
key_sub_57  in  1  debounced sub key level
hour_e_57   out 1  hour field selected for setting
min_e_57    out 1  minute field selected
sec_e_57    out 1  second field selected
week_e_57   out 1  week field selected
add_p_57    out 1  1-cycle increment pulse
sub_p_57    out 1  1-cycle decrement pulse
blink_on_57 out 1  1 = show selected field, 0 = blank it; constant 1 in RUN
time_run_57 out 1  1 = timekeeping advances; 0 only in SET_SEC

Behaviour:
- All outputs are registered. Reset (async assert, sync release) gives state RUN, all *_e = 0, add_p = sub_p = 0, blink_on = 1, time_run = 1, all counters 0, key history registers 0.
- Key edges: rise = level & ~prev, with prev registered every cycle. A key already held at reset release produces no edge.
- FSM, advanced only on a mode rising edge: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> SET_WEEK -> RUN.
- Field enables are one-hot decode of the state, registered, so they are valid the cycle after the state change.
- In RUN, add/sub are ignored and no pulses are emitted.
- Add/sub in a SET state:
  - A rising edge of exactly one of add/sub emits one pulse on the next cycle and starts the hold counter (ms resolution).
  - While that key stays held and the other is low: first repeat pulse after REPEAT_DLY_MS ticks, then one every REPEAT_PER_MS ticks.
  - Release clears the hold counter.
- Every pulse is exactly 1 cycle and is followed by at least 1 low cycle. Downstream edge detectors (week_ctrl_57) see one edge per pulse.
- Simultaneous add+sub (both high): no pulse, hold counter cleared. No pulse resumes until one key is released and the other rises afresh.
- Mode edge has priority over add/sub in the same cycle: state advances, no add/sub pulse, hold counter cleared.
- Mode edge while add is held: repeat stops. Add must be released and re-pressed to adjust the new field.
- Timeout: a ms counter accumulates to MS_PER_S, which increments a seconds-idle counter.
  - Any key rising edge or repeat pulse clears both counters.
  - At TIMEOUT_S the FSM goes to RUN (enables drop, time_run = 1).
  - Counters are cleared on entry to RUN and held at 0 while in RUN.
- Blink: ms counter toggles blink_on every BLINK_HALF_MS ticks in SET states. Blink phase resets to 1 on every state change and every add/sub pulse, so the edited digit is visible immediately.
- time_run_57 = 0 throughout SET_SEC.
- Counter widths: $clog2(max+1); no wrap beyond the terminal value.
- Reset mid-setting returns immediately to RUN. No pulse is emitted in the reset-release cycle.

Decomposition:
- Shared package clk_pkg_57:
  - state encoding localparams ST_RUN, ST_HOUR, ST_MIN, ST_SEC, ST_WEEK (3 bits)
  - MS_PER_S
  - the timing defaults
- One sub-module, key_repeat_57: edge detect plus hold/repeat counter for a single key. Instantiated twice (add, sub); the top level gates the two outputs for mutual exclusion and for mode priority.

Test Plan:
- Reset during SET_MIN with add held -> next cycle RUN, all *_e = 0, no add_p for the whole release period.
- Five mode presses from RUN -> hour_e, min_e, sec_e, week_e, then all 0. time_run = 0 only while sec_e = 1.
- In SET_WEEK, add held 1000 ms (REPEAT_DLY = 600, PER = 150) -> pulses at t ≈ 0, 600, 750, 900 ms (4 total). With week_ctrl_57 attached starting at 6, week wraps 7 -> 1 -> 2 -> 3.
- Add high, then sub rises while add is still held -> no pulse; release both, press sub -> exactly one sub_p.
- In SET_HOUR, no keys for 10 s of ticks -> RUN at the 10 000th ms tick. One add press at 9.9 s -> timeout pushed back to 19.9 s.
- Mode and add rising in the same cycle in SET_HOUR -> state becomes SET_MIN, add_p stays 0; blink_on = 1 for 250 ms, then toggles.
